// File: rtl/regfile_param.sv
// regfile_param: NREAD-port register file, r0 hardwired to zero, self-clearing after reset.
// Optional same-cycle write-through forwarding when REGFILE_BYPASS_EN is defined.
module regfile_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wE,
    input  logic [ADDR_W-1:0]       rW,
    input  logic [DATA_W-1:0]       busW,
    input  logic [NREAD*ADDR_W-1:0] rA,
    output logic [NREAD*DATA_W-1:0] busA,
    output logic                    init_done,
    output logic                    wr_drop
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_ptr, ptr_nxt;
    logic              drop_nxt;
    logic              wr_req;
    logic [DATA_W-1:0] mem [1:DEPTH-1];

    assign wr_req    = wE && rW != '0;
    assign init_done = state == READY;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= ADDR_W'(1);
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= ptr_nxt;
            wr_drop <= drop_nxt;
        end

    always_comb begin
        state_nxt = (state == CLEAR && clr_ptr == LAST) ? READY : state;
        ptr_nxt   = (state == CLEAR) ? clr_ptr + ADDR_W'(1) : clr_ptr;
        drop_nxt  = state == CLEAR && wr_req;
    end

    // Storage has no reset; the clear sequence is the only way it gets zeroed.
    always_ff @(posedge clk)
        if (state == CLEAR)
            mem[clr_ptr] <= '0;
        else if (wr_req)
            mem[rW] <= busW;

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rA[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign busA[k*DATA_W +: DATA_W] = (state == CLEAR || ra == '0) ? '0 :
                                          (wr_req && ra == rW) ? busW : mem[ra];
`else
        assign busA[k*DATA_W +: DATA_W] = (state == CLEAR || ra == '0) ? '0 : mem[ra];
`endif
    end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed self-checking bench for regfile_param (4 read ports, 32 entries).
module tb_regfile_param;
    localparam int DW = 32, AW = 5, NR = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wE = 1'b0;
    logic [AW-1:0]    rW = '0;
    logic [DW-1:0]    busW = '0;
    logic [NR*AW-1:0] rA = '0;
    logic [NR*DW-1:0] busA;
    logic             init_done, wr_drop;
    int               errors = 0, checks = 0;

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
        .clk(clk), .rst_n(rst_n), .wE(wE), .rW(rW), .busW(busW),
        .rA(rA), .busA(busA), .init_done(init_done), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] port(input int k);
        return busA[k*DW +: DW];
    endfunction

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wE = 1'b1; rW = a; busW = d;
        step();
        wE = 1'b0;
    endtask

    task automatic run_clear();
        for (int i = 1; i <= 31; i++) begin
            step();
            checks++;
            if (init_done !== (i == 31)) begin
                errors++;
                $display("FAIL clear_edge%0d init_done=%0b want %0b", i, init_done, i == 31);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wE = 1'b0; rA = {NR{AW'(9)}};
        repeat (3) step();
        checks++;
        if (init_done !== 1'b0 || wr_drop !== 1'b0 || busA !== '0) begin
            errors++;
            $display("FAIL reset init_done=%0b wr_drop=%0b busA=%h want 0 0 0", init_done, wr_drop, busA);
        end
        rst_n = 1'b1;
        run_clear();
        for (int a = 0; a < 32; a++) begin
            rA = {NR{AW'(a)}};
            #1;
            checks++;
            if (busA !== '0) begin
                errors++;
                $display("FAIL zero_r%0d busA=%h want 0", a, busA);
            end
        end
    endtask

    task automatic test_write();
        write(5'd9, 32'hDEADBEEF);
        rA = {AW'(0), AW'(0), AW'(9), AW'(9)};
        #1;
        checks++;
        if (port(0) !== 32'hDEADBEEF || port(1) !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_r9 p0=%h p1=%h want deadbeef", port(0), port(1));
        end
        write(5'd0, 32'h1234);
        rA = '0;
        #1;
        checks++;
        if (port(0) !== '0) begin
            errors++;
            $display("FAIL write_r0 p0=%h want 0", port(0));
        end
    endtask

    task automatic test_drop();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (9) step();
        wE = 1'b1; rW = 5'd8; busW = 32'd5;
        step();
        wE = 1'b0;
        checks++;
        if (wr_drop !== 1'b1) begin
            errors++;
            $display("FAIL drop_pulse wr_drop=%0b want 1", wr_drop);
        end
        step();
        checks++;
        if (wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL drop_fall wr_drop=%0b want 0", wr_drop);
        end
        repeat (20) step();
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL drop_init init_done=%0b want 1 at edge 31", init_done);
        end
        rA = {NR{AW'(8)}};
        #1;
        checks++;
        if (port(0) !== '0) begin
            errors++;
            $display("FAIL drop_r8 p0=%h want 0", port(0));
        end
    endtask

    task automatic test_raw();
        logic [DW-1:0] want;
        write(5'd12, 32'd3);
        wE = 1'b1; rW = 5'd12; busW = 32'd7; rA = {NR{AW'(12)}};
        #1;
`ifdef REGFILE_BYPASS_EN
        want = 32'd7;
`else
        want = 32'd3;
`endif
        checks++;
        if (port(0) !== want) begin
            errors++;
            $display("FAIL raw_same p0=%h want %h", port(0), want);
        end
        step();
        wE = 1'b0;
        #1;
        checks++;
        if (port(0) !== 32'd7) begin
            errors++;
            $display("FAIL raw_next p0=%h want 7", port(0));
        end
        wE = 1'b1; rW = 5'd0; busW = 32'hFFFF; rA = '0;
        #1;
        checks++;
        if (port(0) !== '0) begin
            errors++;
            $display("FAIL raw_r0 p0=%h want 0", port(0));
        end
        step();
        wE = 1'b0;
    endtask

    task automatic test_multi_port();
        for (int i = 1; i <= 4; i++) write(AW'(i), DW'(i));
        rA = {AW'(4), AW'(3), AW'(2), AW'(1)};
        #1;
        for (int k = 0; k < NR; k++) begin
            checks++;
            if (port(k) !== DW'(k + 1)) begin
                errors++;
                $display("FAIL multi_p%0d got=%h want %h", k, port(k), k + 1);
            end
        end
    endtask

    task automatic test_mid_reset();
        write(5'd5, 32'hAA);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (15) step();
        rA = {NR{AW'(5)}};
        #1;
        checks++;
        if (busA !== '0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear busA=%h init_done=%0b want 0 0", busA, init_done);
        end
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (init_done !== 1'b0 || wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset init_done=%0b wr_drop=%0b want 0 0", init_done, wr_drop);
        end
        rst_n = 1'b1;
        run_clear();
        #1;
        checks++;
        if (port(0) !== '0) begin
            errors++;
            $display("FAIL mid_r5 p0=%h want 0", port(0));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_raw();
        test_multi_port();
        test_drop();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
